// File: rtl/i_sram2sram_like_mo_pkg.sv
// Shared constants and helpers for the instruction-fetch bridge.
package isram_bridge_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/i_sram2sram_like_mo_if.sv
// SRAM-like I-cache request/response bundle; master is the fetch bridge.
interface i_sram2sram_like_mo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_addr_ok;
  logic              inst_data_ok;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok
  );
endinterface

// File: rtl/i_sram2sram_like_mo_tracker.sv
// Tracks accepted-but-unreturned requests and how many of them are wrong-path.
// Latency: classification is combinational on resp; counters update next edge.
// Backpressure: can_issue drops while MAX_OUTSTANDING requests are in flight.
module isram_outstanding_tracker
  import isram_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept,
  input  logic resp,
  input  logic flush,
  output logic can_issue,
  output logic is_stale,
  output logic is_live,
  output logic live_pend
);
  localparam int CW = cnt_w(MAX_OUTSTANDING);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] discard_cnt;
  logic          live_ret;
  logic          flush_add;

  assign can_issue = out_cnt < CW'(MAX_OUTSTANDING);
  assign is_stale  = resp & (discard_cnt != '0);
  assign live_ret  = resp & (discard_cnt == '0) & live_pend;
  assign is_live   = live_ret & ~flush;
  // A request accepted in the flush cycle is already wrong-path, so it joins the discard count.
  assign flush_add = flush & ((live_pend & ~live_ret) | accept);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt     <= '0;
      discard_cnt <= '0;
      live_pend   <= 1'b0;
    end else begin
      out_cnt     <= out_cnt + CW'(accept) - CW'(resp);
      discard_cnt <= discard_cnt - CW'(is_stale) + CW'(flush_add);
      if (flush)        live_pend <= 1'b0;
      else if (accept)  live_pend <= 1'b1;
      else if (is_live) live_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/i_sram2sram_like_mo.sv
// Multi-outstanding IF-stage to I-cache bridge; optional ISRAM_BRIDGE_PERF_EN adds perf counters.
// Latency: live data passes through combinationally in the data_ok cycle.
// Backpressure: holds live data across stall_all_i; req stalls at MAX_OUTSTANDING.
module i_sram2sram_like_mo
  import isram_bridge_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_flush_i,
  input  logic [ADDR_W-1:0]    cpu_rom_addr_i,
  input  logic                 cpu_rom_ce_i,
  input  logic                 stall_all_i,
  output logic                 cpu_rom_stall_o,
  output logic [DATA_W-1:0]    cpu_rom_data_o,
`ifdef ISRAM_BRIDGE_PERF_EN
  output logic [31:0]          perf_fetch_cnt_o,
  output logic [31:0]          perf_discard_cnt_o,
`endif
  i_sram2sram_like_mo_if.master cache
);
  logic              can_issue;
  logic              is_stale;
  logic              is_live;
  logic              live_pend;
  logic              accept;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  isram_outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_trk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .accept    (accept),
    .resp      (cache.inst_data_ok),
    .flush     (cpu_flush_i),
    .can_issue (can_issue),
    .is_stale  (is_stale),
    .is_live   (is_live),
    .live_pend (live_pend)
  );

  assign cache.inst_req   = cpu_rom_ce_i & ~live_pend & ~hold_valid & can_issue;
  assign cache.inst_wr    = 1'b0;
  assign cache.inst_size  = SIZE_WORD;
  assign cache.inst_addr  = cpu_rom_addr_i;
  assign cache.inst_wdata = '0;
  assign accept           = cache.inst_req & cache.inst_addr_ok;

  assign cpu_rom_data_o  = is_live ? cache.inst_rdata : hold_data;
  assign cpu_rom_stall_o = (is_live | hold_valid) ? 1'b0 : (cpu_rom_ce_i & ~cpu_flush_i);

  // hold_data tracks every live word so data_o keeps the last delivered instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (is_live) hold_data <= cache.inst_rdata;
      if (is_live && stall_all_i)           hold_valid <= 1'b1;
      else if (cpu_flush_i || !stall_all_i) hold_valid <= 1'b0;
    end
  end

`ifdef ISRAM_BRIDGE_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o   <= '0;
      perf_discard_cnt_o <= '0;
    end else begin
      if (is_live)  perf_fetch_cnt_o   <= perf_fetch_cnt_o + 32'd1;
      if (is_stale) perf_discard_cnt_o <= perf_discard_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_i_sram2sram_like_mo.sv
// Directed bench: dut2 uses MAX_OUTSTANDING=2, dut1 uses MAX_OUTSTANDING=1, shared stimulus.
module tb_i_sram2sram_like_mo;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] addr;
  logic        ce;
  logic        stall_all;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        stall2, stall1;
  logic [31:0] data2, data1;
  int          tests = 0;
  int          fails = 0;
`ifdef ISRAM_BRIDGE_PERF_EN
  logic [31:0] pf2, pd2, pf1, pd1;
`endif

  always #5 clk = ~clk;

  i_sram2sram_like_mo_if #(.ADDR_W(32), .DATA_W(32)) c2 ();
  i_sram2sram_like_mo_if #(.ADDR_W(32), .DATA_W(32)) c1 ();
  assign c2.inst_addr_ok = addr_ok;
  assign c2.inst_data_ok = data_ok;
  assign c2.inst_rdata   = rdata;
  assign c1.inst_addr_ok = addr_ok;
  assign c1.inst_data_ok = data_ok;
  assign c1.inst_rdata   = rdata;

  i_sram2sram_like_mo #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .cpu_flush_i(flush), .cpu_rom_addr_i(addr),
    .cpu_rom_ce_i(ce), .stall_all_i(stall_all), .cpu_rom_stall_o(stall2),
    .cpu_rom_data_o(data2),
`ifdef ISRAM_BRIDGE_PERF_EN
    .perf_fetch_cnt_o(pf2), .perf_discard_cnt_o(pd2),
`endif
    .cache(c2)
  );

  i_sram2sram_like_mo #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cpu_flush_i(flush), .cpu_rom_addr_i(addr),
    .cpu_rom_ce_i(ce), .stall_all_i(stall_all), .cpu_rom_stall_o(stall1),
    .cpu_rom_data_o(data1),
`ifdef ISRAM_BRIDGE_PERF_EN
    .perf_fetch_cnt_o(pf1), .perf_discard_cnt_o(pd1),
`endif
    .cache(c1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; addr = 32'h0; ce = 0; stall_all = 0;
    addr_ok = 0; data_ok = 0; rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    ce = 1;
    #2;
    tests++; if (c2.inst_req !== 1'b1) begin fails++; $display("FAIL reset_req_ce1 got=%0b exp=1", c2.inst_req); end
    tests++; if (stall2 !== 1'b1) begin fails++; $display("FAIL reset_stall_ce1 got=%0b exp=1", stall2); end
    tests++; if (data2 !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", data2); end
    ce = 0;
    #1;
    tests++; if (c2.inst_req !== 1'b0 || stall2 !== 1'b0) begin fails++; $display("FAIL reset_ce0 req=%0b stall=%0b exp=0/0", c2.inst_req, stall2); end
    cyc();
    rst = 0;
    #1;
  endtask

  task automatic test_single_hit();
    do_reset();
    ce = 1; addr = 32'h1000; addr_ok = 1; #1;
    tests++; if (c2.inst_req !== 1'b1 || stall2 !== 1'b1) begin fails++; $display("FAIL hit_c0 req=%0b stall=%0b exp=1/1", c2.inst_req, stall2); end
    tests++; if (c2.inst_addr !== 32'h1000 || c2.inst_size !== 2'b10 || c2.inst_wr !== 1'b0 || c2.inst_wdata !== 32'h0)
      begin fails++; $display("FAIL hit_bus addr=%h size=%b wr=%b wdata=%h exp=1000/10/0/0", c2.inst_addr, c2.inst_size, c2.inst_wr, c2.inst_wdata); end
    cyc();
    addr_ok = 0; #1;
    tests++; if (c2.inst_req !== 1'b0 || stall2 !== 1'b1) begin fails++; $display("FAIL hit_c1 req=%0b stall=%0b exp=0/1", c2.inst_req, stall2); end
    cyc();
    data_ok = 1; rdata = 32'hDEAD_BEEF; #1;
    tests++; if (stall2 !== 1'b0 || data2 !== 32'hDEAD_BEEF || c2.inst_req !== 1'b0)
      begin fails++; $display("FAIL hit_c2 stall=%0b data=%h req=%0b exp=0/deadbeef/0", stall2, data2, c2.inst_req); end
    cyc();
    data_ok = 0; ce = 0; #1;
  endtask

  task automatic test_flush_refetch();
    do_reset();
    ce = 1; addr = 32'hA000; addr_ok = 1; #1;
    cyc();
    flush = 1; #1;
    tests++; if (c2.inst_req !== 1'b0 || stall2 !== 1'b0) begin fails++; $display("FAIL fr_flush req=%0b stall=%0b exp=0/0", c2.inst_req, stall2); end
    cyc();
    flush = 0; addr = 32'h2000; #1;
    tests++; if (c2.inst_req !== 1'b1 || stall2 !== 1'b1) begin fails++; $display("FAIL fr_refetch req=%0b stall=%0b exp=1/1", c2.inst_req, stall2); end
    cyc();
    addr_ok = 0; data_ok = 1; rdata = 32'h1111; #1;
    tests++; if (stall2 !== 1'b1 || data2 !== 32'h0) begin fails++; $display("FAIL fr_stale stall=%0b data=%h exp=1/0", stall2, data2); end
    cyc();
    rdata = 32'h2222; #1;
    tests++; if (stall2 !== 1'b0 || data2 !== 32'h2222) begin fails++; $display("FAIL fr_live stall=%0b data=%h exp=0/2222", stall2, data2); end
    cyc();
    data_ok = 0; ce = 0; #1;
    tests++; if (dut2.u_trk.out_cnt !== 2'd0 || dut2.u_trk.discard_cnt !== 2'd0)
      begin fails++; $display("FAIL fr_drain out=%0d disc=%0d exp=0/0", dut2.u_trk.out_cnt, dut2.u_trk.discard_cnt); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    ce = 1; addr = 32'hA000; addr_ok = 1; #1;
    tests++; if (c1.inst_req !== 1'b1) begin fails++; $display("FAIL lim_first req=%0b exp=1", c1.inst_req); end
    cyc();
    flush = 1; #1;
    cyc();
    flush = 0; addr = 32'hB000; #1;
    for (int i = 0; i < 2; i++) begin
      tests++; if (c1.inst_req !== 1'b0 || stall1 !== 1'b1) begin fails++; $display("FAIL lim_blocked%0d req=%0b stall=%0b exp=0/1", i, c1.inst_req, stall1); end
      cyc();
    end
    data_ok = 1; rdata = 32'hAAAA; #1;
    tests++; if (c1.inst_req !== 1'b0 || stall1 !== 1'b1) begin fails++; $display("FAIL lim_stale req=%0b stall=%0b exp=0/1", c1.inst_req, stall1); end
    cyc();
    data_ok = 0; #1;
    tests++; if (c1.inst_req !== 1'b1) begin fails++; $display("FAIL lim_release req=%0b exp=1", c1.inst_req); end
    cyc();
    addr_ok = 0; data_ok = 1; rdata = 32'hB0B0; #1;
    tests++; if (stall1 !== 1'b0 || data1 !== 32'hB0B0) begin fails++; $display("FAIL lim_live stall=%0b data=%h exp=0/b0b0", stall1, data1); end
    cyc();
    data_ok = 0; ce = 0; #1;
  endtask

  task automatic test_stall_hold();
    do_reset();
    ce = 1; addr = 32'h3000; addr_ok = 1; #1;
    cyc();
    addr_ok = 0; data_ok = 1; rdata = 32'hCAFE_0001; stall_all = 1; #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (stall2 !== 1'b0 || data2 !== 32'hCAFE_0001 || c2.inst_req !== 1'b0)
        begin fails++; $display("FAIL hold_c%0d stall=%0b data=%h req=%0b exp=0/cafe0001/0", i, stall2, data2, c2.inst_req); end
      cyc();
      data_ok = 0; rdata = 32'h0; addr = 32'h3004; #1;
    end
    stall_all = 0; #1;
    tests++; if (dut2.hold_valid !== 1'b1 || stall2 !== 1'b0 || data2 !== 32'hCAFE_0001 || c2.inst_req !== 1'b0)
      begin fails++; $display("FAIL hold_release hv=%0b stall=%0b data=%h req=%0b exp=1/0/cafe0001/0", dut2.hold_valid, stall2, data2, c2.inst_req); end
    cyc();
    tests++; if (dut2.hold_valid !== 1'b0 || c2.inst_req !== 1'b1 || stall2 !== 1'b1)
      begin fails++; $display("FAIL hold_cleared hv=%0b req=%0b stall=%0b exp=0/1/1", dut2.hold_valid, c2.inst_req, stall2); end
    ce = 0; #1;
  endtask

  task automatic test_flush_coincident();
    do_reset();
    ce = 1; addr = 32'h4000; addr_ok = 1; #1;
    cyc();
    addr_ok = 0; flush = 1; data_ok = 1; rdata = 32'h3333; #1;
    tests++; if (stall2 !== 1'b0) begin fails++; $display("FAIL coinc_stall got=%0b exp=0", stall2); end
    cyc();
    flush = 0; data_ok = 0; addr = 32'h5000; addr_ok = 1; #1;
    tests++; if (dut2.u_trk.discard_cnt !== 2'd0 || c2.inst_req !== 1'b1)
      begin fails++; $display("FAIL coinc_next disc=%0d req=%0b exp=0/1", dut2.u_trk.discard_cnt, c2.inst_req); end
    cyc();
    addr_ok = 0; data_ok = 1; rdata = 32'h4444; #1;
    tests++; if (stall2 !== 1'b0 || data2 !== 32'h4444) begin fails++; $display("FAIL coinc_live stall=%0b data=%h exp=0/4444", stall2, data2); end
    cyc();
    data_ok = 0; ce = 0; #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    ce = 1; addr = 32'h6000; addr_ok = 1; #1;
    cyc();
    addr_ok = 0; data_ok = 1; rdata = 32'h5555; #1;
    cyc();
    data_ok = 0; addr = 32'h6004; addr_ok = 1; #1;
    tests++; if (data2 !== 32'h5555) begin fails++; $display("FAIL ar_lastdata got=%h exp=5555", data2); end
    cyc();
    flush = 1; #1;
    cyc();
    flush = 0; addr = 32'h7000; #1;
    cyc();
    addr_ok = 0; #1;
    tests++; if (dut2.u_trk.out_cnt !== 2'd2) begin fails++; $display("FAIL ar_pre_out got=%0d exp=2", dut2.u_trk.out_cnt); end
    #2;
    rst = 1; #1;
    tests++; if (dut2.u_trk.out_cnt !== 2'd0 || dut2.u_trk.discard_cnt !== 2'd0 || dut2.u_trk.live_pend !== 1'b0)
      begin fails++; $display("FAIL ar_counters out=%0d disc=%0d live=%0b exp=0/0/0", dut2.u_trk.out_cnt, dut2.u_trk.discard_cnt, dut2.u_trk.live_pend); end
    tests++; if (data2 !== 32'h0 || c2.inst_req !== 1'b1 || stall2 !== 1'b1)
      begin fails++; $display("FAIL ar_outputs data=%h req=%0b stall=%0b exp=0/1/1", data2, c2.inst_req, stall2); end
    cyc();
    rst = 0; ce = 0; #1;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_hit();
    test_flush_refetch();
    test_outstanding_limit();
    test_stall_hold();
    test_flush_coincident();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
